adc_osr_multichannel: RTL and testbench

Parametrised successor to the single-channel oversampling stage. It is a synchronous, clocked decimator sitting between the SAR control block and the result interface. It accumulates 2^k conversion results per channel for up to CHANNELS time-multiplexed channels. Each window produces a left-aligned result of width OUT_WIDTH with floor(k/2) bits of resolution gain. Results are buffered in an output FIFO with a valid/ready handshake and a sticky overflow flag.

---
 rtl/adc_osr_pkg.sv | 19 +
 rtl/adc_sync_fifo.sv | 54 +++++
 rtl/adc_osr_multichannel.sv | 137 +++++++++++++
 tb/tb_adc_osr_multichannel.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_osr_pkg.sv
// Shared constants and helpers for the multichannel oversampling decimator.
package adc_osr_pkg;

    localparam int unsigned OSR_MAX_LOG2_DEF = 7;

    // Channel tag width, at least one bit even for a single channel.
    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned gain_bits(input int unsigned k);
        return k / 2;
    endfunction

    function automatic int unsigned drop_bits(input int unsigned k);
        return k - k / 2;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Synchronous FIFO with registered storage; head entry is visible on data_o.
module adc_sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_c, full_c, do_push, do_pop;

    // Extra pointer MSB separates full from empty.
    always_comb begin
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_c;
        do_push  = push_i && (!full_c || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_c;
    assign empty_o = empty_c;

endmodule

// File: rtl/adc_osr_multichannel.sv
// Per-channel 2^k oversampling accumulator feeding a result FIFO with
// valid/ready handshake and sticky overflow.
module adc_osr_multichannel
    import adc_osr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned OUT_WIDTH    = 16,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned OSR_MAX_LOG2 = OSR_MAX_LOG2_DEF,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable_in,
    input  logic [2:0]                      osr_mode_in,
    input  logic                            data_valid_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [chan_width(CHANNELS)-1:0] data_channel_in,
    output logic [OUT_WIDTH-1:0]            result_out,
    output logic [chan_width(CHANNELS)-1:0] result_channel_out,
    output logic                            result_valid_out,
    input  logic                            result_ready_in,
    output logic                            overflow_out,
    input  logic                            overflow_clear_in
);

    localparam int unsigned CH_W  = chan_width(CHANNELS);
    localparam int unsigned ACC_W = DATA_WIDTH + OSR_MAX_LOG2;
    localparam int unsigned CNT_W = OSR_MAX_LOG2;
    localparam int unsigned PAY_W = CH_W + OUT_WIDTH;

    logic [2:0]           osr_q;
    logic [ACC_W-1:0]     acc_q [CHANNELS];
    logic [ACC_W-1:0]     acc_d [CHANNELS];
    logic [CNT_W-1:0]     cnt_q [CHANNELS];
    logic [CNT_W-1:0]     cnt_d [CHANNELS];
    logic                 overflow_q, overflow_d;

    int unsigned          k_sat;
    logic [CNT_W-1:0]     window_last;
    logic                 mode_change, accept;
    logic [ACC_W-1:0]     sum_c, shifted_c;
    logic                 push_c, pop_c;
    logic [OUT_WIDTH-1:0] push_res;
    logic [CH_W-1:0]      push_ch;
    logic [PAY_W-1:0]     head;
    logic                 fifo_full, fifo_empty;

    // Window length comes from the registered mode, saturated to the maximum.
    always_comb begin
        k_sat       = (32'(osr_q) > OSR_MAX_LOG2) ? OSR_MAX_LOG2 : 32'(osr_q);
        window_last = CNT_W'((32'd1 << k_sat) - 32'd1);
        mode_change = (osr_q != osr_mode_in);
        accept      = enable_in && data_valid_in && !mode_change &&
                      (32'(data_channel_in) < CHANNELS);
    end

    // Accumulate the tagged channel; a completing sample emits and restarts.
    always_comb begin
        sum_c     = '0;
        shifted_c = '0;
        push_c    = 1'b0;
        push_res  = '0;
        push_ch   = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            acc_d[c] = acc_q[c];
            cnt_d[c] = cnt_q[c];
            if (!enable_in || mode_change) begin
                acc_d[c] = '0;
                cnt_d[c] = '0;
            end else if (accept && (data_channel_in == CH_W'(c))) begin
                sum_c = acc_q[c] + ACC_W'(data_in);
                if (cnt_q[c] == window_last) begin
                    acc_d[c]  = '0;
                    cnt_d[c]  = '0;
                    shifted_c = sum_c >> drop_bits(k_sat);
                    push_c    = 1'b1;
                    push_res  = OUT_WIDTH'(shifted_c)
                                << (OUT_WIDTH - DATA_WIDTH - gain_bits(k_sat));
                    push_ch   = CH_W'(c);
                end else begin
                    acc_d[c] = sum_c;
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // A push that finds the FIFO full with no concurrent pop is dropped.
    always_comb begin
        pop_c      = !fifo_empty && result_ready_in;
        overflow_d = overflow_q;
        if (push_c && fifo_full && !pop_c) begin
            overflow_d = 1'b1;
        end else if (overflow_clear_in) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_q      <= '0;
            overflow_q <= 1'b0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            osr_q      <= osr_mode_in;
            overflow_q <= overflow_d;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                acc_q[c] <= acc_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    adc_sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  ({push_ch, push_res}),
        .pop_i   (pop_c),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign result_out         = head[OUT_WIDTH-1:0];
    assign result_channel_out = head[PAY_W-1 -: CH_W];
    assign result_valid_out   = !fifo_empty;
    assign overflow_out       = overflow_q;

endmodule

// File: tb/tb_adc_osr_multichannel.sv
// Scoreboard bench for adc_osr_multichannel: expected results are queued as
// stimulus is driven and compared as the DUT hands results over.
module tb_adc_osr_multichannel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_in;
    logic [2:0]  osr_mode_in;
    logic        data_valid_in;
    logic [11:0] data_in;
    logic [1:0]  data_channel_in;
    logic [15:0] result_out;
    logic [1:0]  result_channel_out;
    logic        result_valid_out;
    logic        result_ready_in;
    logic        overflow_out;
    logic        overflow_clear_in;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q [$];

    always #5 clk = ~clk;

    adc_osr_multichannel #(
        .DATA_WIDTH   (12),
        .OUT_WIDTH    (16),
        .CHANNELS     (3),
        .OSR_MAX_LOG2 (7),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable_in          (enable_in),
        .osr_mode_in        (osr_mode_in),
        .data_valid_in      (data_valid_in),
        .data_in            (data_in),
        .data_channel_in    (data_channel_in),
        .result_out         (result_out),
        .result_channel_out (result_channel_out),
        .result_valid_out   (result_valid_out),
        .result_ready_in    (result_ready_in),
        .overflow_out       (overflow_out),
        .overflow_clear_in  (overflow_clear_in)
    );

    // Every accepted handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid_out && result_ready_in) begin
            logic [17:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got ch=%0d res=%h, none expected",
                         result_channel_out, result_out);
            end else begin
                e = exp_q.pop_front();
                if ({result_channel_out, result_out} !== e) begin
                    failures++;
                    $display("FAIL result got ch=%0d res=%h expected ch=%0d res=%h",
                             result_channel_out, result_out, e[17:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [11:0] d);
        data_valid_in   = 1'b1;
        data_channel_in = ch;
        data_in         = d;
        tick();
        data_valid_in   = 1'b0;
    endtask

    task automatic set_mode(input logic [2:0] k);
        osr_mode_in = k;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_in = 1'b1;
        osr_mode_in = 3'd0;
        data_valid_in = 1'b0;
        data_in = '0;
        data_channel_in = '0;
        result_ready_in = 1'b1;
        overflow_clear_in = 1'b0;
        #12;
        checks += 4;
        if (result_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", result_valid_out); end
        if (result_out !== 16'h0) begin failures++; $display("FAIL reset_result got %h expected 0000", result_out); end
        if (result_channel_out !== 2'd0) begin failures++; $display("FAIL reset_channel got %0d expected 0", result_channel_out); end
        if (overflow_out !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b expected 0", overflow_out); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        set_mode(3'd0);
        result_ready_in = 1'b1;
        exp_q.push_back({2'd0, 16'hABC0});
        data_valid_in = 1'b1; data_channel_in = 2'd0; data_in = 12'hABC;
        checks++;
        if (result_valid_out !== 1'b0) begin failures++; $display("FAIL k0_valid_before got %b expected 0", result_valid_out); end
        tick();
        data_valid_in = 1'b0;
        checks++;
        if (result_valid_out !== 1'b1) begin failures++; $display("FAIL k0_valid_latency got %b expected 1", result_valid_out); end
        exp_q.push_back({2'd2, 16'h1230});
        send(2'd2, 12'h123);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || result_valid_out); i++) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL k0_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_osr2();
        set_mode(3'd2);
        for (int i = 0; i < 3; i++) begin
            send(2'd1, 12'h800);
            checks++;
            if (result_valid_out !== 1'b0) begin failures++; $display("FAIL k2_early_valid sample=%0d got %b expected 0", i, result_valid_out); end
        end
        exp_q.push_back({2'd1, 16'h8000});
        send(2'd1, 12'h800);
        checks++;
        if (result_valid_out !== 1'b1) begin failures++; $display("FAIL k2_valid got %b expected 1", result_valid_out); end
        for (int i = 0; i < 20 && (exp_q.size() != 0 || result_valid_out); i++) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL k2_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_osr7_interleave();
        set_mode(3'd7);
        exp_q.push_back({2'd0, 16'hFFF0});
        exp_q.push_back({2'd1, 16'h0010});
        for (int i = 0; i < 128; i++) begin
            send(2'd0, 12'hFFF);
            send(2'd1, 12'h001);
        end
        for (int i = 0; i < 20 && (exp_q.size() != 0 || result_valid_out); i++) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL k7_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        set_mode(3'd0);
        result_ready_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({2'd0, 16'(i << 4)});
            send(2'd0, 12'(i));
            if (i == 4) begin
                checks++;
                if (overflow_out !== 1'b0) begin failures++; $display("FAIL ovf_at_full got %b expected 0", overflow_out); end
            end
        end
        checks++;
        if (overflow_out !== 1'b1) begin failures++; $display("FAIL ovf_set got %b expected 1", overflow_out); end
        overflow_clear_in = 1'b1;
        tick();
        overflow_clear_in = 1'b0;
        checks++;
        if (overflow_out !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b expected 0", overflow_out); end
        // Push and pop together while full: no drop.
        exp_q.push_back({2'd0, 16'h0060});
        result_ready_in = 1'b1;
        send(2'd0, 12'h006);
        result_ready_in = 1'b0;
        checks++;
        if (overflow_out !== 1'b0) begin failures++; $display("FAIL ovf_push_pop got %b expected 0", overflow_out); end
        // Overflow and clear in the same cycle: set wins.
        overflow_clear_in = 1'b1;
        send(2'd0, 12'h007);
        overflow_clear_in = 1'b0;
        checks++;
        if (overflow_out !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got %b expected 1", overflow_out); end
        overflow_clear_in = 1'b1;
        tick();
        overflow_clear_in = 1'b0;
        result_ready_in = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || result_valid_out); i++) tick();
        checks++;
        if (exp_q.size() != 0 || overflow_out !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain got %0d pending ovf=%b expected 0 pending ovf=0", exp_q.size(), overflow_out);
        end
    endtask

    task automatic test_mode_change();
        set_mode(3'd2);
        send(2'd0, 12'h100);
        send(2'd0, 12'h100);
        osr_mode_in = 3'd1;
        send(2'd0, 12'hFFF);
        send(2'd3, 12'hFFF);
        send(2'd0, 12'h400);
        checks++;
        if (result_valid_out !== 1'b0) begin failures++; $display("FAIL mode_stale_valid got %b expected 0", result_valid_out); end
        send(2'd3, 12'hFFF);
        exp_q.push_back({2'd0, 16'h4000});
        send(2'd0, 12'h400);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || result_valid_out); i++) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL mode_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        set_mode(3'd2);
        result_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) send(2'd0, 12'h400);
        send(2'd1, 12'h7FF);
        send(2'd1, 12'h7FF);
        checks++;
        if (result_valid_out !== 1'b1) begin failures++; $display("FAIL rmid_fill got %b expected 1", result_valid_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result_valid_out !== 1'b0 || result_out !== 16'h0 || result_channel_out !== 2'd0 || overflow_out !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got valid=%b res=%h ch=%0d ovf=%b expected all 0",
                     result_valid_out, result_out, result_channel_out, overflow_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (result_valid_out !== 1'b0) begin failures++; $display("FAIL rmid_empty got %b expected 0", result_valid_out); end
        result_ready_in = 1'b1;
        exp_q.push_back({2'd1, 16'h1000});
        for (int i = 0; i < 4; i++) send(2'd1, 12'h100);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || result_valid_out); i++) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_osr2();
        test_osr7_interleave();
        test_overflow();
        test_mode_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
